// File: rtl/add_3_if.sv
// Operand/result bundle for add_3: three 4-bit operands in, registered nibble and overflow out.
// There is no handshake: a new operand set is sampled on every rising clock edge.
interface add_3_if;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] c;
   logic [3:0] sum;
   logic       ov;

   modport master (
      output a,
      output b,
      output c,
      input  sum,
      input  ov
   );

   modport slave (
      input  a,
      input  b,
      input  c,
      output sum,
      output ov
   );
endinterface

// File: rtl/add_3.sv
// Registered three-operand 4-bit unsigned adder (carry-save row + ripple add, one cycle latency).
// Define ADD3_SAT_EN to clamp sum to 15 whenever ov is set; the default build wraps modulo 16.
module add_3 (
   input  logic   clk,
   input  logic   rst,
   add_3_if.slave bus
);

   logic [3:0] s;
   logic [3:0] k;
   logic [4:1] cy;
   logic [5:0] t;
   logic [3:0] sum_d;
   logic       ov_d;
   logic [3:0] sum_q;
   logic       ov_q;

   // Carry-save row: four full adders, each bit independent.
   assign s = bus.a ^ bus.b ^ bus.c;
   assign k = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);

   // Ripple add of s and {k,1'b0}; bit 0 has nothing to add to s[0].
   assign t[0]  = s[0];
   assign cy[1] = 1'b0;

   for (genvar i = 1; i < 4; i++) begin : g_ripple
      assign t[i]    = s[i] ^ k[i-1] ^ cy[i];
      assign cy[i+1] = (s[i] & k[i-1]) | (cy[i] & (s[i] ^ k[i-1]));
   end

   assign t[4] = k[3] ^ cy[4];
   assign t[5] = k[3] & cy[4];

   assign ov_d = t[5] | t[4];

`ifdef ADD3_SAT_EN
   assign sum_d = ov_d ? 4'd15 : t[3:0];
`else
   assign sum_d = t[3:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= 4'd0;
         ov_q  <= 1'b0;
      end else begin
         sum_q <= sum_d;
         ov_q  <= ov_d;
      end
   end

   assign bus.sum = sum_q;
   assign bus.ov  = ov_q;

endmodule

// File: tb/tb_add_3.sv
// Self-checking bench for add_3: directed cases, exhaustive sweep with mid-stream reset,
// back-to-back alternation, mid-cycle input changes and random traffic vs. an arithmetic model.
module tb_add_3;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   // {ov, sum} expected for each edge, pushed when the operands are driven.
   logic [4:0] exp_q[$];

   add_3_if bus ();

   add_3 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   function automatic logic [4:0] model(input int a, input int b, input int c, input bit r);
      int total;
      int res;
      bit over;
      total = a + b + c;
      over  = total > 15;
      res   = total % 16;
`ifdef ADD3_SAT_EN
      if (over) res = 15;
`endif
      if (r) return 5'd0;
      return {over, 4'(res)};
   endfunction

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got ov=%b sum=%0d, expected ov=%b sum=%0d",
                  tag, got[4], got[3:0], exp[4], exp[3:0]);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input string tag, input int a, input int b, input int c, input bit r);
      logic [4:0] exp;
      @(negedge clk);
      bus.a = 4'(a);
      bus.b = 4'(b);
      bus.c = 4'(c);
      rst   = r;
      exp_q.push_back(model(a, b, c, r));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         exp = exp_q.pop_front();
         check_eq(tag, {bus.ov, bus.sum}, exp);
      end
   endtask

   // Operands changing between edges must not disturb the registered outputs.
   task automatic glitch_check(input int a, input int b, input int c);
      logic [4:0] held;
      drive("glitch_base", a, b, c, 1'b0);
      held = model(a, b, c, 1'b0);
      #1;
      bus.a = 4'($urandom_range(0, 15));
      bus.b = 4'($urandom_range(0, 15));
      bus.c = 4'($urandom_range(0, 15));
      #1;
      check_eq("glitch_hold", {bus.ov, bus.sum}, held);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_errors = 0;
      rst   = 1'b1;
      bus.a = 4'd7;
      bus.b = 4'd7;
      bus.c = 4'd7;

      // Reset held two cycles with a=b=c=7, then first result 21 -> 5 / ov.
      drive("reset_0", 7, 7, 7, 1'b1);
      drive("reset_1", 7, 7, 7, 1'b1);
      drive("post_reset", 7, 7, 7, 1'b0);

      // Boundary around 15, maximum and all zeros.
      drive("edge_15", 5, 6, 4, 1'b0);
      drive("edge_16", 5, 6, 5, 1'b0);
      drive("max_45", 15, 15, 15, 1'b0);
      drive("zeros", 0, 0, 0, 1'b0);
      drive("c_full", 0, 0, 15, 1'b0);
      drive("ab_only", 15, 1, 0, 1'b0);

      // Exhaustive sweep, a fastest, with a one-cycle reset in the middle.
      for (int c = 0; c < 16; c++)
         for (int b = 0; b < 16; b++)
            for (int a = 0; a < 16; a++)
               drive("sweep", a, b, c, (c == 7 && b == 13 && a == 4));

      // Back-to-back alternation with no bubble.
      for (int i = 0; i < 8; i++) begin
         drive("alt_max", 15, 15, 15, 1'b0);
         drive("alt_one", 0, 0, 1, 1'b0);
      end

      for (int i = 0; i < 6; i++)
         glitch_check($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++)
         drive("random", $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               ($urandom_range(0, 15) == 0));

      // ---------------- report ----------------
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
